arbiter_wrr_hs: RTL and testbench

Registered weighted round-robin arbiter with a downstream acknowledge handshake, for multi-beat shared resources such as bus ports and FIFO write sides. Up to REQ_NUM requesters compete. A winner keeps the grant for up to its programmed weight of acknowledged beats. After that, priority rotates to the requester after the winner. It generalises the single-cycle rotating-priority arbiter with per-requester weights, grant hold, early release and a registered one-hot/encoded grant.

---
 rtl/arbiter_wrr_hs_if.sv | 40 ++++
 rtl/arbiter_wrr_hs.sv | 174 +++++++++++++++++
 tb/tb_arbiter_wrr_hs.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/arbiter_wrr_hs_if.sv
`default_nettype none
// ============================================================================
// Module      : arbiter_wrr_hs_if
// Description : Handshake bundle between a set of requesters and the
//               weighted round-robin arbiter.
//                 req     requester -> arbiter  request vector
//                 weight  requester -> arbiter  packed per-requester weights
//                 ack     sink      -> arbiter  one beat accepted this cycle
//                 gnt     arbiter   -> all      registered one-hot grant
//                 gnt_vld arbiter   -> all      grant valid
//                 gnt_id  arbiter   -> all      encoded granted index
//                 credit  arbiter   -> all      beats left in current grant
//               master = requester/sink side, slave = arbiter side.
// Revision    : 1.0  initial release
// ============================================================================
interface arbiter_wrr_hs_if #(
  parameter int REQ_NUM  = 4,
  parameter int WEIGHT_W = 4
);
  localparam int IDX_W = $clog2(REQ_NUM);

  logic [REQ_NUM-1:0]          req;
  logic [REQ_NUM*WEIGHT_W-1:0] weight;
  logic                        ack;
  logic [REQ_NUM-1:0]          gnt;
  logic                        gnt_vld;
  logic [IDX_W-1:0]            gnt_id;
  logic [WEIGHT_W-1:0]         credit;

  modport master (
    output req, weight, ack,
    input  gnt, gnt_vld, gnt_id, credit
  );

  modport slave (
    input  req, weight, ack,
    output gnt, gnt_vld, gnt_id, credit
  );
endinterface
`default_nettype wire

// File: rtl/arbiter_wrr_hs.sv
`default_nettype none
// ============================================================================
// Module      : arbiter_wrr_hs
// Description : Registered weighted round-robin arbiter with downstream
//               acknowledge. A winner keeps the grant for up to its weight
//               of acknowledged beats (weight 0 counts as 1), or until it
//               drops its request; priority then rotates to the index after
//               the winner and the next grant loads with no idle bubble.
// Ports       : clk    rising-edge clock
//               rst_n  asynchronous active-low reset
//               bus    arbiter_wrr_hs_if.slave (req/weight/ack in,
//                      gnt/gnt_vld/gnt_id/credit out, all registered)
// Revision    : 1.0  initial release
// ============================================================================
module arbiter_wrr_hs #(
  parameter int REQ_NUM  = 4,
  parameter int WEIGHT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  arbiter_wrr_hs_if.slave  bus
);

  localparam int                  IDX_W       = $clog2(REQ_NUM);
  localparam logic [IDX_W-1:0]    LAST_IDX    = IDX_W'(REQ_NUM - 1);
  // One extra bit so ptr + offset can be reduced modulo REQ_NUM.
  localparam logic [IDX_W:0]      REQ_NUM_EXT = (IDX_W + 1)'(REQ_NUM);
  localparam logic [WEIGHT_W-1:0] ONE_BEAT    = WEIGHT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t              state_q,  state_d;
  logic [IDX_W-1:0]    ptr_q,    ptr_d;
  logic [REQ_NUM-1:0]  gnt_q,    gnt_d;
  logic [IDX_W-1:0]    gnt_id_q, gnt_id_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d;

  // --------------------------------------------------------------------------
  // Effective weights: a zero field is promoted to a single beat.
  // --------------------------------------------------------------------------
  logic [WEIGHT_W-1:0] weight_eff [REQ_NUM];

  generate
    for (genvar g = 0; g < REQ_NUM; g++) begin : g_weight
      logic [WEIGHT_W-1:0] w_raw;
      assign w_raw         = bus.weight[g*WEIGHT_W +: WEIGHT_W];
      assign weight_eff[g] = (w_raw == '0) ? ONE_BEAT : w_raw;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Grant termination and pointer rotation
  // --------------------------------------------------------------------------
  logic             exhausted;
  logic             released;
  logic             grant_end;
  logic [IDX_W-1:0] rot_ptr;
  logic [IDX_W-1:0] arb_ptr;

  always_comb begin
    exhausted = bus.ack && (credit_q == ONE_BEAT);
    // Early release wins even if the same cycle carries an ack; that beat
    // is still considered accepted by the sink.
    released  = !bus.req[gnt_id_q];
    grant_end = (state_q == ST_BUSY) && (exhausted || released);
    rot_ptr   = (gnt_id_q == LAST_IDX) ? '0 : gnt_id_q + 1'b1;
    // At grant end the search already starts past the outgoing winner, so a
    // requester only wins twice in a row when nobody else is asking.
    arb_ptr   = grant_end ? rot_ptr : ptr_q;
  end

  // --------------------------------------------------------------------------
  // Rotating-priority search: first set req scanning arb_ptr upwards, wrapping.
  // --------------------------------------------------------------------------
  logic             arb_found;
  logic [IDX_W-1:0] arb_idx;
  logic [IDX_W:0]   cand;

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int k = 0; k < REQ_NUM; k++) begin
      cand = {1'b0, arb_ptr} + (IDX_W + 1)'(k);
      if (cand >= REQ_NUM_EXT) begin
        cand = cand - REQ_NUM_EXT;
      end
      if (!arb_found && bus.req[cand[IDX_W-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state / next-output logic
  // --------------------------------------------------------------------------
  logic load_grant;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    credit_d   = credit_q;
    load_grant = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // ack is meaningless without a grant and is ignored here.
        if (arb_found) begin
          load_grant = 1'b1;
        end
      end

      ST_BUSY: begin
        if (grant_end) begin
          ptr_d = rot_ptr;
          if (arb_found) begin
            load_grant = 1'b1;
          end else begin
            state_d  = ST_IDLE;
            gnt_d    = '0;
            gnt_id_d = '0;
            credit_d = '0;
          end
        end else if (bus.ack) begin
          // credit > 1 here, otherwise grant_end would have fired.
          credit_d = credit_q - ONE_BEAT;
        end
      end
    endcase

    // Weight is sampled only at grant load; later changes do not affect the
    // grant in progress.
    if (load_grant) begin
      state_d         = ST_BUSY;
      gnt_d           = '0;
      gnt_d[arb_idx]  = 1'b1;
      gnt_id_d        = arb_idx;
      credit_d        = weight_eff[arb_idx];
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      credit_q <= credit_d;
    end
  end

  // gnt_vld mirrors the BUSY flop, so every output comes straight from a flop.
  assign bus.gnt     = gnt_q;
  assign bus.gnt_vld = (state_q == ST_BUSY);
  assign bus.gnt_id  = gnt_id_q;
  assign bus.credit  = credit_q;

endmodule
`default_nettype wire

// File: tb/tb_arbiter_wrr_hs.sv
`default_nettype none
// ============================================================================
// Module      : tb_arbiter_wrr_hs
// Description : Directed self-checking bench for arbiter_wrr_hs with
//               hand-computed expected grant/credit sequences.
// Revision    : 1.0  initial release
// ============================================================================
module tb_arbiter_wrr_hs;

  localparam int REQ_NUM  = 4;
  localparam int WEIGHT_W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  arbiter_wrr_hs_if #(.REQ_NUM(REQ_NUM), .WEIGHT_W(WEIGHT_W)) bus ();

  arbiter_wrr_hs #(.REQ_NUM(REQ_NUM), .WEIGHT_W(WEIGHT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    bus.req    = '0;
    bus.ack    = 1'b0;
    bus.weight = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic chk_grant(input string tag, input int id, input int cr);
    chk({tag, "_gnt"},    32'(bus.gnt),     32'(1) << id);
    chk({tag, "_id"},     32'(bus.gnt_id),  32'(id));
    chk({tag, "_credit"}, 32'(bus.credit),  32'(cr));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_gnt"},    32'(bus.gnt),     32'd0);
    chk({tag, "_vld"},    32'(bus.gnt_vld), 32'd0);
    chk({tag, "_id"},     32'(bus.gnt_id),  32'd0);
    chk({tag, "_credit"}, 32'(bus.credit),  32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_id2 [11] = '{0, 0, 0, 0, 1, 1, 2, 3, 3, 3, 0};
    int exp_cr2 [11] = '{4, 3, 2, 1, 2, 1, 1, 3, 2, 1, 4};
    int exp_cr3 [7]  = '{4, 3, 3, 2, 2, 1, 1};
    int exp_id1 [4]  = '{0, 2, 0, 2};

    // Reset state
    do_reset();
    chk_idle("rst");

    // Two requesters, weight 1, continuous ack: alternate every cycle
    bus.weight = {4'd1, 4'd1, 4'd1, 4'd1};
    bus.req    = 4'b0101;
    bus.ack    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_grant($sformatf("alt%0d", i), exp_id1[i], 1);
      chk($sformatf("alt%0d_vld", i), 32'(bus.gnt_vld), 32'd1);
    end

    // All requesting, weights {3,1,2,4} for requesters 3..0
    do_reset();
    bus.weight = {4'd3, 4'd1, 4'd2, 4'd4};
    bus.req    = 4'b1111;
    bus.ack    = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick();
      chk_grant($sformatf("wrr%0d", i), exp_id2[i], exp_cr2[i]);
    end

    // Ack every other cycle: credit moves only on ack beats
    do_reset();
    bus.weight = {4'd0, 4'd0, 4'd1, 4'd4};
    bus.req    = 4'b0011;
    bus.ack    = 1'b0;
    tick();
    chk_grant("pulse_ld", 0, 4);
    for (int i = 0; i < 7; i++) begin
      bus.ack = (i % 2 == 1);
      tick();
      chk_grant($sformatf("pulse%0d", i), 0, exp_cr3[i]);
    end
    bus.ack = 1'b1;
    tick();
    chk_grant("pulse_hand", 1, 1);

    // Early release of requester 1 after two acks; weight-0 field acts as 1
    do_reset();
    bus.weight = {4'd1, 4'd0, 4'd5, 4'd1};
    bus.req    = 4'b1110;
    bus.ack    = 1'b1;
    tick();
    chk_grant("early_ld", 1, 5);
    tick();
    chk_grant("early_a1", 1, 4);
    tick();
    chk_grant("early_a2", 1, 3);
    bus.req = 4'b1100;
    tick();
    chk_grant("early_rel", 2, 1);
    tick();
    chk_grant("early_next", 3, 1);

    // Sole requester re-wins back-to-back, then drops to idle
    do_reset();
    bus.weight = {4'd2, 4'd0, 4'd0, 4'd0};
    bus.req    = 4'b1000;
    bus.ack    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_grant($sformatf("sole%0d", i), 3, (i % 2 == 0) ? 2 : 1);
    end
    bus.req = 4'b0000;
    tick();
    chk_idle("sole_drop");

    // Maximum weight holds for 15 beats
    do_reset();
    bus.weight = {4'd0, 4'd0, 4'd1, 4'd15};
    bus.req    = 4'b0011;
    bus.ack    = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk_grant($sformatf("max%0d", i), 0, 15 - i);
    end
    tick();
    chk_grant("max_hand", 1, 1);

    // Asynchronous reset mid-grant, then restart from requester 0 pointer
    do_reset();
    bus.weight = {4'd0, 4'd0, 4'd0, 4'd3};
    bus.req    = 4'b0001;
    bus.ack    = 1'b0;
    tick();
    chk_grant("arst_pre", 0, 3);
    rst_n = 1'b0;
    #2;
    chk_idle("arst_now");
    bus.req    = 4'b1010;
    bus.weight = {4'd1, 4'd1, 4'd1, 4'd1};
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk_grant("arst_post", 1, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
